// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants: fetch FSM encodings, instruction width,
// PC increment, NOP encoding and the fetch-fault predicate.
package mips_pkg;

    typedef enum logic [1:0] {
        FS_RUN   = 2'd0,
        FS_HOLD  = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_e;

    localparam int unsigned        INSTR_W   = 32;
    localparam logic [31:0]        PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // A fetch faults on a misaligned byte address or a word index past the memory end.
    function automatic logic pc_fault(input logic [31:0] pc, input logic [31:0] mem_words);
        return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= mem_words);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction-memory port, redirect/halt controls and the
// valid/ready decode stage. Perf counter outputs exist only under FETCH_PERF_EN.
interface fetch_ctrl_if;
    import mips_pkg::*;

    logic [31:0]        mem_addr;
    logic [INSTR_W-1:0] mem_data;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               halt_req;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [31:0]        if_pc;
    logic               fault;
    logic [31:0]        fault_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]        perf_fetch_cnt;
    logic [31:0]        perf_stall_cnt;
`endif

    modport master (
`ifdef FETCH_PERF_EN
        output perf_fetch_cnt,
        output perf_stall_cnt,
`endif
        output mem_addr,
        output if_valid,
        output if_instr,
        output if_pc,
        output fault,
        output fault_pc,
        input  mem_data,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        input  if_ready
    );

    modport slave (
`ifdef FETCH_PERF_EN
        input  perf_fetch_cnt,
        input  perf_stall_cnt,
`endif
        input  mem_addr,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  fault,
        input  fault_pc,
        output mem_data,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        output if_ready
    );

endinterface

// File: rtl/fetch_perf.sv
// Fetch performance counters: instructions loaded and cycles stalled by decode.
// Instantiated by fetch_ctrl only when FETCH_PERF_EN is defined.
module fetch_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_stall,
    output logic [31:0] o_fetch_cnt,
    output logic [31:0] o_stall_cnt
);

    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    // Free-running counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (i_load) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (i_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads combinational instruction memory
// and registers each word into a valid/ready stage. Optional counters: FETCH_PERF_EN.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MEM_WORDS = 32'h0010_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [31:0]        r_pc;
    logic [31:0]        w_pc_nxt;
    logic               r_if_valid;
    logic               w_if_valid_nxt;
    logic [INSTR_W-1:0] r_if_instr;
    logic [31:0]        r_if_pc;
    logic               r_fault;
    logic               w_fault_nxt;
    logic [31:0]        r_fault_pc;
    logic               w_fault_set;
    logic               w_load;
    logic               w_load_slot;

    assign w_load_slot = !r_if_valid || bus.if_ready;

    // Next-state, PC and output-stage control; redirect overrides every state
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_valid_nxt = r_if_valid;
        w_fault_nxt    = r_fault;
        w_fault_set    = 1'b0;
        w_load         = 1'b0;
        if (bus.redirect_valid) begin
            w_pc_nxt       = bus.redirect_pc;
            w_if_valid_nxt = 1'b0;
            w_fault_nxt    = 1'b0;
            w_state_nxt    = bus.halt_req ? FS_HOLD : FS_RUN;
        end else begin
            case (r_state)
                FS_RUN: begin
                    if (bus.halt_req) begin
                        w_state_nxt    = FS_HOLD;
                        w_if_valid_nxt = r_if_valid && !bus.if_ready;
                    end else if (w_load_slot) begin
                        if (pc_fault(r_pc, MEM_WORDS)) begin
                            w_if_valid_nxt = 1'b0;
                            w_fault_nxt    = 1'b1;
                            w_fault_set    = 1'b1;
                            w_state_nxt    = FS_FAULT;
                        end else begin
                            w_load         = 1'b1;
                            w_if_valid_nxt = 1'b1;
                            w_pc_nxt       = r_pc + PC_STEP;
                        end
                    end else begin
                        w_if_valid_nxt = r_if_valid;
                    end
                end
                FS_HOLD: begin
                    w_if_valid_nxt = r_if_valid && !bus.if_ready;
                    if (!bus.halt_req) begin
                        w_state_nxt = FS_RUN;
                    end else begin
                        w_state_nxt = FS_HOLD;
                    end
                end
                FS_FAULT: begin
                    w_if_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt    = FS_RUN;
                    w_if_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FS_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, output stage and fault registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_INSTR;
            r_if_pc    <= 32'd0;
            r_fault    <= 1'b0;
            r_fault_pc <= 32'd0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_fault    <= w_fault_nxt;
            if (w_load) begin
                r_if_instr <= bus.mem_data;
                r_if_pc    <= r_pc;
            end
            if (w_fault_set) begin
                r_fault_pc <= r_pc;
            end
        end
    end

    assign bus.mem_addr = {2'b00, r_pc[31:2]};
    assign bus.if_valid = r_if_valid;
    assign bus.if_instr = r_if_instr;
    assign bus.if_pc    = r_if_pc;
    assign bus.fault    = r_fault;
    assign bus.fault_pc = r_fault_pc;

`ifdef FETCH_PERF_EN
    logic        w_stall;
    logic [31:0] w_fetch_cnt;
    logic [31:0] w_stall_cnt;

    assign w_stall = r_if_valid && !bus.if_ready;

    fetch_perf u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_stall     (w_stall),
        .o_fetch_cnt (w_fetch_cnt),
        .o_stall_cnt (w_stall_cnt)
    );

    assign bus.perf_fetch_cnt = w_fetch_cnt;
    assign bus.perf_stall_cnt = w_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: scoreboarded delivery checks plus direct checks of
// reset, backpressure, redirect, faults and halt. Perf checks under FETCH_PERF_EN.
module tb_fetch_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic sb_en;
    logic [63:0] sb_q[$];

    fetch_ctrl_if bus ();
    fetch_ctrl_if sbus ();

    fetch_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (32'd16)
    ) u_sdut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] widx);
        return {16'hC0DE, widx[15:0]};
    endfunction

    assign bus.mem_data  = mem_word(bus.mem_addr);
    assign sbus.mem_data = mem_word(sbus.mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_push(input logic [31:0] pc);
        sb_q.push_back({pc, mem_word(pc >> 2)});
    endtask

    // Scoreboard: every accepted (not flushed) instruction must match the queue head
    always @(negedge clk) begin
        logic [63:0] exp_item;
        if (sb_en && bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_pc", bus.if_pc, 32'hFFFF_FFFF);
            end else begin
                exp_item = sb_q.pop_front();
                chk("sb_pc", bus.if_pc, exp_item[63:32]);
                chk("sb_instr", bus.if_instr, exp_item[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        sb_en = 1'b0;
        rst_n = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'd0;
        bus.halt_req        = 1'b0;
        bus.if_ready        = 1'b1;
        sbus.redirect_valid = 1'b0;
        sbus.redirect_pc    = 32'd0;
        sbus.halt_req       = 1'b0;
        sbus.if_ready       = 1'b1;
        step(3);
        chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_instr", bus.if_instr, 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_fault", {31'd0, bus.fault}, 32'd0);
        chk("rst_fault_pc", bus.fault_pc, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetch", bus.perf_fetch_cnt, 32'd0);
        chk("rst_perf_stall", bus.perf_stall_cnt, 32'd0);
`endif

        // Reset release: A,B,C,D in cycles 1..4
        sb_push(32'h0);
        sb_push(32'h4);
        sb_push(32'h8);
        sb_en = 1'b1;
        rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step(1);
            chk("seq_valid", {31'd0, bus.if_valid}, 32'd1);
            chk("seq_if_pc", bus.if_pc, 32'(4 * (c - 1)));
            chk("seq_instr", bus.if_instr, mem_word(32'(c - 1)));
        end
        bus.if_ready = 1'b0;
        rst_n = 1'b0;
        step(2);
        chk("sb_drain_seq", 32'(sb_q.size()), 32'd0);
        chk("midrst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("midrst_if_pc", bus.if_pc, 32'd0);

        // Backpressure on word 1 for three cycles
        sb_push(32'h0);
        sb_push(32'h4);
        bus.if_ready = 1'b1;
        rst_n = 1'b1;
        step(2);
        chk("bp_first_pc", bus.if_pc, 32'h4);
        bus.if_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            chk("bp_instr", bus.if_instr, mem_word(32'd1));
            chk("bp_if_pc", bus.if_pc, 32'h4);
            chk("bp_mem_addr", bus.mem_addr, 32'd2);
        end
`ifdef FETCH_PERF_EN
        chk("bp_perf_stall", bus.perf_stall_cnt, 32'd3);
`endif
        bus.if_ready = 1'b1;
        step(1);
        chk("bp_next_pc", bus.if_pc, 32'h8);

        // Redirect to 0x40 while word 2 is valid; word 2 is flushed
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        sb_push(32'h40);
        step(1);
        bus.redirect_valid = 1'b0;
        chk("redir_n1_valid", {31'd0, bus.if_valid}, 32'd0);
        step(1);
        chk("redir_n2_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("redir_n2_pc", bus.if_pc, 32'h40);
        chk("redir_n2_instr", bus.if_instr, mem_word(32'd16));
`ifdef FETCH_PERF_EN
        chk("redir_perf_fetch", bus.perf_fetch_cnt, 32'd4);
`endif
        sb_push(32'h44);
        step(2);

        // Misaligned redirect faults; a later aligned redirect recovers
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h2;
        step(1);
        bus.redirect_valid = 1'b0;
        chk("mis_n1_fault", {31'd0, bus.fault}, 32'd0);
        step(1);
        chk("mis_fault", {31'd0, bus.fault}, 32'd1);
        chk("mis_fault_pc", bus.fault_pc, 32'h2);
        chk("mis_valid", {31'd0, bus.if_valid}, 32'd0);
        step(2);
        chk("mis_valid_hold", {31'd0, bus.if_valid}, 32'd0);
        chk("mis_fault_hold", {31'd0, bus.fault}, 32'd1);
        sb_push(32'h8);
        sb_push(32'hC);
        sb_push(32'h10);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8;
        step(1);
        bus.redirect_valid = 1'b0;
        chk("rec_fault_clr", {31'd0, bus.fault}, 32'd0);
        step(1);
        chk("rec_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("rec_if_pc", bus.if_pc, 32'h8);
        step(3);

        // Halt while word 5 is pending: drain, stay empty, resume at 0x18
        chk("halt_pend_pc", bus.if_pc, 32'h14);
        bus.if_ready = 1'b0;
        bus.halt_req = 1'b1;
        sb_push(32'h14);
        step(2);
        chk("halt_pend_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("halt_mem_addr", bus.mem_addr, 32'd6);
        bus.if_ready = 1'b1;
        step(1);
        chk("halt_drained", {31'd0, bus.if_valid}, 32'd0);
        step(2);
        chk("halt_idle", {31'd0, bus.if_valid}, 32'd0);
        chk("halt_pc_hold", bus.mem_addr, 32'd6);
        bus.halt_req = 1'b0;
        sb_push(32'h18);
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (bus.if_valid) break;
        end
        chk("resume_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("resume_pc", bus.if_pc, 32'h18);
        @(negedge clk);
        #1;
        sb_en = 1'b0;
        chk("sb_drain_end", 32'(sb_q.size()), 32'd0);

        // Out-of-range fault with MEM_WORDS = 16
        sbus.redirect_valid = 1'b1;
        sbus.redirect_pc    = 32'h38;
        step(1);
        sbus.redirect_valid = 1'b0;
        chk("oor_n1_valid", {31'd0, sbus.if_valid}, 32'd0);
        chk("oor_n1_fault", {31'd0, sbus.fault}, 32'd0);
        step(1);
        chk("oor_w14_pc", sbus.if_pc, 32'h38);
        chk("oor_w14_instr", sbus.if_instr, mem_word(32'd14));
        step(1);
        chk("oor_w15_pc", sbus.if_pc, 32'h3C);
        chk("oor_w15_instr", sbus.if_instr, mem_word(32'd15));
        step(1);
        chk("oor_fault", {31'd0, sbus.fault}, 32'd1);
        chk("oor_fault_pc", sbus.fault_pc, 32'h40);
        chk("oor_valid", {31'd0, sbus.if_valid}, 32'd0);

        // Redirect in the same cycle as a fault condition wins
        sbus.redirect_valid = 1'b1;
        sbus.redirect_pc    = 32'h3C;
        step(1);
        sbus.redirect_valid = 1'b0;
        step(1);
        chk("race_pre_pc", sbus.if_pc, 32'h3C);
        sbus.redirect_valid = 1'b1;
        sbus.redirect_pc    = 32'h20;
        step(1);
        sbus.redirect_valid = 1'b0;
        chk("race_no_fault", {31'd0, sbus.fault}, 32'd0);
        step(1);
        chk("race_fault_late", {31'd0, sbus.fault}, 32'd0);
        chk("race_pc", sbus.if_pc, 32'h20);

        // Halt together with redirect: redirected but nothing fetched until halt drops
        sbus.halt_req       = 1'b1;
        sbus.redirect_valid = 1'b1;
        sbus.redirect_pc    = 32'h0;
        step(1);
        sbus.redirect_valid = 1'b0;
        chk("hr_valid", {31'd0, sbus.if_valid}, 32'd0);
        step(2);
        chk("hr_idle", {31'd0, sbus.if_valid}, 32'd0);
        chk("hr_mem_addr", sbus.mem_addr, 32'd0);
        sbus.halt_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (sbus.if_valid) break;
        end
        chk("hr_resume_valid", {31'd0, sbus.if_valid}, 32'd1);
        chk("hr_resume_pc", sbus.if_pc, 32'h0);
        chk("hr_resume_instr", sbus.if_instr, mem_word(32'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
